// File: rtl/saver_sd_card.sv
// rtl/saver_sd_card.sv - pulls an image from the core upload port into a 512-byte sector buffer
// and writes each full sector to the selected SD image slot.
module saver_sd_card #(
  parameter logic [7:0]  PAD_BYTE   = 8'h00,
  parameter logic [31:0] WR_TIMEOUT = 32'd1500000
) (
  input  logic        clk,
  input  logic        system_reset_n,
  input  logic        save_start,
  input  logic [2:0]  img_select,
  input  logic [22:0] save_size,
  output logic [31:0] sd_lba,
  output logic [4:0]  sd_wr,
  input  logic        sd_busy,
  input  logic        sd_done,
  input  logic [8:0]  sd_byte_index,
  input  logic        sd_wr_byte_strobe,
  output logic [7:0]  sd_wr_data,
  output logic        ioctl_upload,
  output logic [22:0] ioctl_addr,
  output logic        ioctl_rd,
  input  logic [7:0]  ioctl_din,
  input  logic        ioctl_din_strobe,
  input  logic        ioctl_wait,
  output logic        saver_busy,
  output logic        save_done,
  output logic        save_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_WAIT,
    S_PAD,
    S_WR_REQ,
    S_WR_WAIT_DONE,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [22:0] r_size;
  logic [2:0]  r_slot;
  logic [22:0] r_addr;
  logic [8:0]  r_cnt;
  logic [31:0] r_lba;
  logic [4:0]  r_sd_wr;
  logic [31:0] r_timer;
  logic        r_upload;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic        r_rd;
  logic [7:0]  r_rd_data;
  logic [7:0]  r_buf [0:511];

  logic        w_accept;
  logic        w_reject;
  logic        w_empty;
  logic        w_issue_rd;
  logic        w_store;
  logic        w_pad;
  logic        w_timeout;
  logic        w_last;
  logic        w_buf_we;
  logic [7:0]  w_buf_wdata;
  logic [4:0]  w_slot_onehot;
  logic        w_unused;

  // The SD controller's byte strobe is informational only; the buffer is read by index.
  assign w_unused = sd_wr_byte_strobe;

  always_comb begin
    w_slot_onehot = 5'b00000;
    case (r_slot)
      3'd1:    w_slot_onehot = 5'b00001;
      3'd2:    w_slot_onehot = 5'b00010;
      3'd3:    w_slot_onehot = 5'b00100;
      3'd4:    w_slot_onehot = 5'b01000;
      3'd5:    w_slot_onehot = 5'b10000;
      default: w_slot_onehot = 5'b00000;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_empty      = 1'b0;
    w_issue_rd   = 1'b0;
    w_store      = 1'b0;
    w_pad        = 1'b0;
    w_timeout    = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (save_start) begin
          if (img_select == 3'd0 || img_select > 3'd5) begin
            w_reject = 1'b1;
          end else if (save_size == 23'd0) begin
            w_empty = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_next_state = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (r_addr >= r_size) begin
          w_next_state = S_PAD;
        end else if (!ioctl_wait) begin
          w_issue_rd   = 1'b1;
          w_next_state = S_FETCH_WAIT;
        end
      end
      S_FETCH_WAIT: begin
        if (ioctl_din_strobe) begin
          w_store      = 1'b1;
          w_next_state = (r_cnt == 9'd511) ? S_WR_REQ : S_FETCH;
        end
      end
      S_PAD: begin
        w_pad = 1'b1;
        if (r_cnt == 9'd511) begin
          w_next_state = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        w_next_state = S_WR_WAIT_DONE;
      end
      S_WR_WAIT_DONE: begin
        // A completion arriving in the expiry cycle still counts as success.
        if (sd_done) begin
          w_next_state = S_NEXT;
        end else if (r_timer <= 32'd1) begin
          w_timeout    = 1'b1;
          w_next_state = S_FINISH;
        end
      end
      S_NEXT: begin
        if (r_addr >= r_size) begin
          w_last       = 1'b1;
          w_next_state = S_FINISH;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_FINISH: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign w_buf_we    = w_store | w_pad;
  assign w_buf_wdata = w_store ? ioctl_din : PAD_BYTE;

  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[r_cnt] <= w_buf_wdata;
    end
  end

  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_state   <= S_IDLE;
      r_size    <= 23'd0;
      r_slot    <= 3'd0;
      r_addr    <= 23'd0;
      r_cnt     <= 9'd0;
      r_lba     <= 32'd0;
      r_sd_wr   <= 5'd0;
      r_timer   <= 32'd0;
      r_upload  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_rd      <= 1'b0;
      r_rd_data <= 8'd0;
    end else begin
      r_state <= w_next_state;
      r_rd    <= w_issue_rd;
      r_done  <= w_empty | w_last;
      r_error <= w_reject | w_timeout;

      if (w_accept) begin
        r_size   <= save_size;
        r_slot   <= img_select;
        r_lba    <= 32'd0;
        r_addr   <= 23'd0;
        r_cnt    <= 9'd0;
        r_upload <= 1'b1;
        r_busy   <= 1'b1;
      end

      if (w_store) begin
        r_addr <= r_addr + 23'd1;
        r_cnt  <= r_cnt + 9'd1;
      end

      if (w_pad) begin
        r_cnt <= r_cnt + 9'd1;
      end

      if (r_state == S_WR_REQ) begin
        r_sd_wr <= w_slot_onehot;
        r_timer <= WR_TIMEOUT;
      end

      if (r_state == S_WR_WAIT_DONE) begin
        r_rd_data <= r_buf[sd_byte_index];
        r_timer   <= r_timer - 32'd1;
        if (sd_busy || sd_done || w_timeout) begin
          r_sd_wr <= 5'd0;
        end
      end

      if (r_state == S_NEXT) begin
        r_lba <= r_lba + 32'd1;
      end

      if (r_state == S_FINISH) begin
        r_upload <= 1'b0;
        r_busy   <= 1'b0;
        r_sd_wr  <= 5'd0;
      end
    end
  end

  assign sd_lba       = r_lba;
  assign sd_wr        = r_sd_wr;
  assign sd_wr_data   = r_rd_data;
  assign ioctl_upload = r_upload;
  assign ioctl_addr   = r_addr;
  assign ioctl_rd     = r_rd;
  assign saver_busy   = r_busy;
  assign save_done    = r_done;
  assign save_error   = r_error;

endmodule

// File: doc/saver_sd_card.md
# saver_sd_card

Write-back path from the C64 core to the SD card: on a save request it pulls image bytes from the core over an ioctl upload handshake, assembles them in a 512-byte sector buffer, and hands each full sector to the SD controller as a write request for the selected image slot. It sits between the core's upload port and the shared SD controller, next to the SD image loader, and is used to persist PRG/FLT/TAP style images after the core modifies them.

## Interface
Parameters:
- PAD_BYTE, 8'h00, fill value for buffer bytes beyond save_size in the last sector
- WR_TIMEOUT, 32'd1500000, max cycles from sd_wr assertion to sd_done before abort

Ports:
- clk  in  1  system clock; all logic on rising edge
- system_reset_n  in  1  asynchronous, active-low reset
- save_start  in  1  one-cycle save request
- img_select  in  3  image slot 1..5 to write
- save_size  in  23  image length in bytes
- sd_lba  out  32  sector number within image, 0-based
- sd_wr  out  5  write request, one-hot target (bit n-1 for slot n)
- sd_busy  in  1  SD controller accepted request
- sd_done  in  1  SD controller finished sector
- sd_byte_index  in  9  byte address SD controller is fetching
- sd_wr_byte_strobe  in  1  SD controller consumes a byte
- sd_wr_data  out  8  buffer byte at sd_byte_index
- ioctl_upload  out  1  high for the whole save
- ioctl_addr  out  23  byte offset being fetched from core
- ioctl_rd  out  1  one-cycle fetch request
- ioctl_din  in  8  byte from core
- ioctl_din_strobe  in  1  ioctl_din valid this cycle
- ioctl_wait  in  1  core not ready for a new ioctl_rd
- saver_busy  out  1  save in progress
- save_done  out  1  one-cycle pulse on successful completion
- save_error  out  1  one-cycle pulse on reject or timeout

## Operation
- States: IDLE, FETCH, FETCH_WAIT, PAD, WR_REQ, WR_WAIT_DONE, NEXT, FINISH.
- IDLE: save_start with img_select in 1..5 and save_size≠0 → latch size/slot, sd_lba←0, addr←0, cnt←0, ioctl_upload←1, saver_busy←1, → FETCH. img_select 0/6/7 → save_error pulse, stay IDLE. save_size 0 → save_done pulse, no SD access. save_start while not IDLE ignored.
- FETCH: if addr ≥ save_size → PAD; else when ~ioctl_wait pulse ioctl_rd with ioctl_addr=addr, → FETCH_WAIT.
- FETCH_WAIT: on ioctl_din_strobe write buffer[cnt]←ioctl_din, addr+1, cnt+1; cnt wrapped to 0 (sector full) → WR_REQ, else → FETCH.
- PAD: write buffer[cnt]←PAD_BYTE one byte/cycle until cnt wraps → WR_REQ.
- WR_REQ: sd_wr←one-hot(slot), timeout counter←WR_TIMEOUT, → WR_WAIT_DONE. sd_wr cleared on first cycle sd_busy high.
- WR_WAIT_DONE: buffer read port serves sd_byte_index; on sd_done → NEXT; counter hits 0 → save_error, → FINISH.
- NEXT: sd_lba+1; addr ≥ save_size → save_done, → FINISH; else → FETCH.
- FINISH: ioctl_upload←0, saver_busy←0, sd_wr←0, → IDLE.
- Sectors written = ceil(save_size/512); addr/cnt widths 23/9 bits, cnt wraps 511→0.

## Timing
- Reset (async, any state): every output 0, state IDLE, buffer contents don't-care; an in-flight SD write is abandoned (sd_wr dropped).
- save_start → ioctl_upload/saver_busy high next cycle; first ioctl_rd no earlier than 2 cycles after save_start.
- ioctl_rd: single cycle, never while ioctl_wait high, never a second before ioctl_din_strobe; ioctl_addr stable from ioctl_rd until strobe. Strobe outside FETCH_WAIT ignored.
- sd_wr_data: registered buffer read, valid the cycle after sd_byte_index is presented (1-cycle latency); byte strobe does not alter buffer.
- sd_wr asserted the cycle after entering WR_REQ, held until sd_busy seen, never asserted twice per sector.
- sd_done and timeout expiry in same cycle: sd_done wins.
- save_done/save_error: exactly one cycle, never both for one save.

## Test plan
- Reset: pulse system_reset_n low mid-WR_WAIT_DONE → all outputs 0 immediately, sd_wr 0, next save_start accepted normally.
- Save slot 2, size 1024, core returns addr[7:0] after 3-cycle latency → sd_wr=5'b00010 twice, sd_lba 0 then 1, SD reads byte k = k[7:0], save_done once.
- Save slot 5, size 700 → two sectors; sector 1 bytes 0..187 = data 512..699, bytes 188..511 = 8'h00; ioctl_rd count exactly 700.
- ioctl_wait held high 50 cycles mid-sector → no ioctl_rd during that window, data order intact.
- No sd_done after sd_wr, WR_TIMEOUT=100 → save_error after 100 cycles, saver_busy low, no save_done.
- save_start with img_select 0 → save_error pulse, no ioctl_rd; save_size 0 → save_done, no sd_wr.
